// File: rtl/aes_decipher_block.sv
// Iterative AES-128/256 inverse cipher: one round per five cycles, InvSubBytes one word per cycle
// through an external inverse S-box. Optional macro AES_DECIPHER_KEYLEN_LATCH_EN latches keylen at start.
`timescale 1ns/1ps
module aes_decipher_block #(
  parameter logic [3:0] AES128_ROUNDS = 4'ha,
  parameter logic [3:0] AES256_ROUNDS = 4'he
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [31:0]  inv_sboxw,
  input  logic [31:0]  new_inv_sboxw,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    SBOX = 2'd2,
    MAIN = 2'd3
  } state_t;

  state_t       state_r, state_nxt_s;
  logic [127:0] block_r, block_nxt_s;
  logic [3:0]   round_ctr_r, round_ctr_nxt_s;
  logic [1:0]   sword_ctr_r, sword_ctr_nxt_s;
  logic         ready_r, ready_nxt_s;
  logic         keylen_s;
  logic [3:0]   nr_s;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm09(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction

  function automatic logic [7:0] gm0b(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction

  function automatic logic [7:0] gm0d(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction

  function automatic logic [7:0] gm0e(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gm0e(a0) ^ gm0b(a1) ^ gm0d(a2) ^ gm09(a3),
            gm09(a0) ^ gm0e(a1) ^ gm0b(a2) ^ gm0d(a3),
            gm0d(a0) ^ gm09(a1) ^ gm0e(a2) ^ gm0b(a3),
            gm0b(a0) ^ gm0d(a1) ^ gm09(a2) ^ gm0e(a3)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
  endfunction

  // Row r of each column comes from column (c - r) mod 4 of the input.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    return {s[127:120], s[23:16],   s[47:40],  s[71:64],
            s[95:88],   s[119:112], s[15:8],   s[39:32],
            s[63:56],   s[87:80],   s[111:104], s[7:0],
            s[31:24],   s[55:48],   s[79:72],  s[103:96]};
  endfunction

  function automatic logic [31:0] get_word(input logic [127:0] s, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = s[127:96];
      2'd1:    w = s[95:64];
      2'd2:    w = s[63:32];
      default: w = s[31:0];
    endcase
    return w;
  endfunction

  function automatic logic [127:0] put_word(input logic [127:0] s, input logic [1:0] idx,
                                            input logic [31:0] w);
    logic [127:0] r;
    r = s;
    case (idx)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

`ifdef AES_DECIPHER_KEYLEN_LATCH_EN
  logic keylen_r;

  // Capture keylen on the edge that accepts next.
  always_ff @(posedge clk) begin
    if (reset) begin
      keylen_r <= 1'b0;
    end else if ((state_r == IDLE) && next) begin
      keylen_r <= keylen;
    end else begin
      keylen_r <= keylen_r;
    end
  end

  assign keylen_s = (state_r == IDLE) ? keylen : keylen_r;
`else
  assign keylen_s = keylen;
`endif

  assign nr_s = keylen_s ? AES256_ROUNDS : AES128_ROUNDS;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, datapath update and S-box word selection.
  always_comb begin
    state_nxt_s     = state_r;
    block_nxt_s     = block_r;
    round_ctr_nxt_s = round_ctr_r;
    sword_ctr_nxt_s = sword_ctr_r;
    ready_nxt_s     = ready_r;
    inv_sboxw       = 32'h0;
    case (state_r)
      IDLE: begin
        if (next) begin
          round_ctr_nxt_s = nr_s;
          ready_nxt_s     = 1'b0;
          state_nxt_s     = INIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      INIT: begin
        block_nxt_s     = inv_shift_rows(block ^ round_key);
        round_ctr_nxt_s = nr_s - 4'd1;
        sword_ctr_nxt_s = 2'd0;
        state_nxt_s     = SBOX;
      end
      SBOX: begin
        inv_sboxw       = get_word(block_r, sword_ctr_r);
        block_nxt_s     = put_word(block_r, sword_ctr_r, new_inv_sboxw);
        sword_ctr_nxt_s = sword_ctr_r + 2'd1;
        if (sword_ctr_r == 2'd3) begin
          state_nxt_s = MAIN;
        end else begin
          state_nxt_s = SBOX;
        end
      end
      MAIN: begin
        if (round_ctr_r != 4'd0) begin
          block_nxt_s     = inv_shift_rows(inv_mix_columns(block_r ^ round_key));
          round_ctr_nxt_s = round_ctr_r - 4'd1;
          state_nxt_s     = SBOX;
        end else begin
          // Final round has no InvMixColumns.
          block_nxt_s = block_r ^ round_key;
          ready_nxt_s = 1'b1;
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      block_r     <= 128'h0;
      round_ctr_r <= 4'd0;
      sword_ctr_r <= 2'd0;
      ready_r     <= 1'b1;
    end else begin
      block_r     <= block_nxt_s;
      round_ctr_r <= round_ctr_nxt_s;
      sword_ctr_r <= sword_ctr_nxt_s;
      ready_r     <= ready_nxt_s;
    end
  end

  assign round     = round_ctr_r;
  assign new_block = block_r;
  assign ready     = ready_r;

endmodule
